// File: rtl/slt_result_checker.sv
// Scoreboard for the ALU set-less-than unit. Each accepted a/b/c triple is
// checked against a locally computed golden SLT result. A run tracks pass and
// fail counts, a sticky fail flag and the first failing triple. A run ends
// after a programmable number of accepted samples.
module slt_result_checker #(
  parameter int unsigned W      = 6,
  parameter bit          SIGNED = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [W-1:0]     first_a,
  output logic [W-1:0]     first_b,
  output logic [W-1:0]     first_c
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] sample_q;

  logic             lt;
  logic [W-1:0]     exp_res;
  logic             mismatch;
  logic             accept;
  logic [CNT_W-1:0] pass_inc;
  logic [CNT_W-1:0] fail_inc;
  logic [CNT_W-1:0] sample_inc;
  logic             last;

  // Golden less-than, signedness fixed at elaboration.
  if (SIGNED) begin : g_signed
    always_comb begin
      lt = ($signed(a) < $signed(b));
    end
  end else begin : g_unsigned
    always_comb begin
      lt = (a < b);
    end
  end

  // Compare the full result word and form saturating increments.
  always_comb begin
    exp_res    = '0;
    exp_res[0] = lt;
    mismatch   = (c != exp_res);
    accept     = in_valid && in_ready;
    pass_inc   = (pass_cnt == '1) ? pass_cnt : pass_cnt + CNT_W'(1);
    fail_inc   = (fail_cnt == '1) ? fail_cnt : fail_cnt + CNT_W'(1);
    sample_inc = (sample_q == '1) ? sample_q : sample_q + CNT_W'(1);
    // A zero sample budget means the run never ends.
    last       = (num_q != '0) && (sample_inc == num_q);
  end

  // Run control FSM with registered status, counters and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      num_q    <= '0;
      sample_q <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      first_a  <= '0;
      first_b  <= '0;
      first_c  <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // Start has priority; no sample can be accepted outside RUN.
          if (start) begin
            state_q  <= StRun;
            num_q    <= num_samples;
            sample_q <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            fail     <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            first_a  <= '0;
            first_b  <= '0;
            first_c  <= '0;
          end
        end
        StRun: begin
          if (accept) begin
            sample_q <= sample_inc;
            if (mismatch) begin
              fail_cnt <= fail_inc;
              // Only the failure that raises the sticky flag is captured.
              if (!fail) begin
                fail    <= 1'b1;
                first_a <= a;
                first_b <= b;
                first_c <= c;
              end
            end else begin
              pass_cnt <= pass_inc;
            end
            if (last) begin
              state_q  <= StDone;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
